pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Parametrised pipeline stage register for the 5-stage RISC-V core. It is the generic replacement for the fixed inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a datapath bus and a control bus with a valid bit and a ready/valid handshake, so hazard logic can stall and flush.
- Optional 2-entry skid buffer (registered ready) breaks long stall-propagation paths.

Parameters:
- DATA_W, 101, datapath payload width in bits (EX/MEM default: alu_result 32 + write_data 32 + rd 5 + pc_plus4 32).
- CTRL_W, 4, control payload width in bits (EX/MEM default: reg_write 1 + result_src 2 + mem_write 1).
- SKID, 0:
  - 0 = single register, combinational ready.
  - 1 = 2-entry skid buffer, registered ready.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous squash of all held entries (branch mispredict / trap).
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- out_valid  out  1  stage presents a valid instruction.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  datapath payload to next stage.
- out_ctrl  out  CTRL_W  control payload to next stage.

Behaviour:
- Handshakes:
  - Accept = in_valid & in_ready.
  - Emit = out_valid & out_ready.
  - All state updates occur on the rising clk edge.
- Reset (async):
  - out_valid=0, out_data=0, out_ctrl=0, all internal entries invalid and zeroed.
  - in_ready=1 after reset for both SKID values.
- Bubble gating: whenever out_valid=0, out_ctrl is forced to 0 and out_data to 0. A bubble must never write the register file or memory.
- Stability: once out_valid=1 and not emitted, out_data/out_ctrl hold constant until the emit edge or flush.
- SKID=0:
  - in_ready = ~out_valid | out_ready (combinational).
  - On accept, the register loads the payload and out_valid=1 next cycle (latency 1).
  - On emit without accept, out_valid=0 next cycle.
  - Simultaneous accept and emit gives back-to-back throughput of 1/cycle.
- SKID=1:
  - States: EMPTY, ONE, FULL. Main entry drives the outputs; the skid entry captures overflow.
  - in_ready is a registered signal equal to (state != FULL).
  - EMPTY: accept -> ONE.
  - ONE:
    - accept & emit -> ONE (main reloads).
    - accept only -> FULL (payload into skid).
    - emit only -> EMPTY.
  - FULL:
    - emit -> ONE (skid moves to main).
    - no accept is possible.
  - Latency 1; sustained throughput 1/cycle with out_ready held high.
- Flush:
  - Highest priority; overrides accept and emit in the same cycle.
  - Next cycle: all entries invalid, payloads zeroed, state EMPTY, in_ready=1.
  - A payload presented with in_valid during the flush cycle is dropped, not captured.
- Reset mid-operation: asynchronously discards all entries regardless of state. No partial transfer is reported.
- No internal arithmetic. Payload bits pass unmodified.

Optional Feature:
- Macro: PIPE_STAGE_PERF_EN.
- Defined:
  - Adds output ports stall_cnt (32) and bubble_cnt (32).
  - stall_cnt increments on every cycle with out_valid & ~out_ready.
  - bubble_cnt increments on every cycle with out_valid=0.
  - Both wrap modulo 2^32, reset to 0 by reset only; flush does not clear them.
- Undefined: the ports and counters are absent. Functional behaviour is identical.

Test Plan:
- SKID=0, out_ready=1, in_valid=1 for 4 cycles with in_data=1,2,3,4 -> out_data 1,2,3,4 on the 4 cycles starting one cycle later, out_valid continuous.
- SKID=0, hold out_ready=0 for 3 cycles after in_data=0xAA accepted -> in_ready=0, out_data stays 0xAA. Release -> single emit of 0xAA, no duplicate.
- SKID=1, feed 0x11,0x22,0x33 with out_ready=0 -> 0x11 and 0x22 held (FULL), in_ready=0, 0x33 not accepted. Raise out_ready -> emits 0x11 then 0x22 in order.
- Flush with one entry held, in_ctrl=4'hF presented that cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1. 4'hF is never emitted.
- Assert reset asynchronously mid-stall (SKID=1, FULL) -> outputs 0 immediately without a clk edge; after release in_ready=1, state EMPTY.
- With PIPE_STAGE_PERF_EN, run 5 stall cycles and 3 bubble cycles, then flush -> stall_cnt=5, bubble_cnt>=3, counters unchanged by flush.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic inter-stage register for the 5-stage core.
// Carries a datapath bus and a control bus under a valid/ready handshake,
// with flush for mispredict/trap squash. SKID=0 gives a single register with
// combinational ready. SKID=1 gives a 2-entry skid buffer with registered ready.
// Optional perf counters (stall_cnt, bubble_cnt) are enabled by defining
// PIPE_STAGE_PERF_EN.
//
// SKID=1 states:
//   state   | meaning
//   S_EMPTY | no entry held, outputs are a bubble
//   S_ONE   | main entry valid and driving the outputs, skid entry empty
//   S_FULL  | main and skid entries both valid, upstream is held off
module pipe_stage_reg #(
  parameter int DATA_W = 101,
  parameter int CTRL_W = 4,
  parameter int SKID   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  logic              main_valid;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] main_ctrl;

  generate
    if (SKID == 0) begin : g_single
      logic              valid_q;
      logic [DATA_W-1:0] data_q;
      logic [CTRL_W-1:0] ctrl_q;
      logic              accept;

      assign in_ready = ~valid_q | out_ready;
      assign accept   = in_valid & in_ready;

      // Single payload register; drained entries are zeroed so a bubble carries no payload.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          ctrl_q  <= '0;
        end else if (flush) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          ctrl_q  <= '0;
        end else if (accept) begin
          valid_q <= 1'b1;
          data_q  <= in_data;
          ctrl_q  <= in_ctrl;
        end else if (out_ready) begin
          valid_q <= 1'b0;
          data_q  <= '0;
          ctrl_q  <= '0;
        end
      end

      assign main_valid = valid_q;
      assign main_data  = data_q;
      assign main_ctrl  = ctrl_q;
    end else begin : g_skid
      typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

      state_t            state_q, state_d;
      logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
      logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
      logic              in_ready_q;
      logic              accept, emit;

      assign accept = in_valid & in_ready_q;
      assign emit   = (state_q != S_EMPTY) & out_ready;

      // State and entry registers; ready is registered from the next state to cut the stall path.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          state_q     <= S_EMPTY;
          main_data_q <= '0;
          main_ctrl_q <= '0;
          skid_data_q <= '0;
          skid_ctrl_q <= '0;
          in_ready_q  <= 1'b1;
        end else begin
          state_q     <= state_d;
          main_data_q <= main_data_d;
          main_ctrl_q <= main_ctrl_d;
          skid_data_q <= skid_data_d;
          skid_ctrl_q <= skid_ctrl_d;
          in_ready_q  <= (state_d != S_FULL);
        end
      end

      // Next-state and entry movement; flush overrides any accept or emit.
      always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;
        case (state_q)
          S_EMPTY: begin
            if (accept) begin
              main_data_d = in_data;
              main_ctrl_d = in_ctrl;
              state_d     = S_ONE;
            end
          end
          S_ONE: begin
            if (accept && emit) begin
              main_data_d = in_data;
              main_ctrl_d = in_ctrl;
            end else if (accept) begin
              skid_data_d = in_data;
              skid_ctrl_d = in_ctrl;
              state_d     = S_FULL;
            end else if (emit) begin
              main_data_d = '0;
              main_ctrl_d = '0;
              state_d     = S_EMPTY;
            end
          end
          S_FULL: begin
            if (emit) begin
              main_data_d = skid_data_q;
              main_ctrl_d = skid_ctrl_q;
              skid_data_d = '0;
              skid_ctrl_d = '0;
              state_d     = S_ONE;
            end
          end
          default: state_d = S_EMPTY;
        endcase
        if (flush) begin
          state_d     = S_EMPTY;
          main_data_d = '0;
          main_ctrl_d = '0;
          skid_data_d = '0;
          skid_ctrl_d = '0;
        end
      end

      assign in_ready   = in_ready_q;
      assign main_valid = (state_q != S_EMPTY);
      assign main_data  = main_data_q;
      assign main_ctrl  = main_ctrl_q;
    end
  endgenerate

  // A bubble must never carry control bits that could write the register file or memory.
  assign out_valid = main_valid;
  assign out_data  = main_valid ? main_data : '0;
  assign out_ctrl  = main_valid ? main_ctrl : '0;

`ifdef PIPE_STAGE_PERF_EN
  // Free-running stall and bubble counters; only reset clears them, flush does not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
      if (!main_valid) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=0 and one SKID=1 instance share the same
// upstream/downstream stimulus; each has its own scoreboard queue of accepted
// payloads that is popped and compared on every emit.
module tb_pipe_stage_reg;
  localparam int DATA_W = 101;
  localparam int CTRL_W = 4;
  localparam int PW     = DATA_W + CTRL_W;

  logic              clk = 1'b0;
  logic              reset;
  logic              flush;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              out_ready;

  logic              in_ready0, out_valid0, in_ready1, out_valid1;
  logic [DATA_W-1:0] out_data0, out_data1;
  logic [CTRL_W-1:0] out_ctrl0, out_ctrl1;
`ifdef PIPE_STAGE_PERF_EN
  logic [31:0]       stall_cnt0, bubble_cnt0, stall_cnt1, bubble_cnt1;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [PW-1:0] q0[$];
  logic [PW-1:0] q1[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0)) dut0 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0), .out_ctrl(out_ctrl0)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt0), .bubble_cnt(bubble_cnt0)
`endif
  );

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1), .out_ctrl(out_ctrl1)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt1), .bubble_cnt(bubble_cnt1)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c,
                       input logic ordy, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    flush     = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: sample handshakes at the falling edge, i.e. the values the next rising edge sees.
  always @(negedge clk) begin
    logic [PW-1:0] e;
    if (reset || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (out_valid0 && out_ready) begin
        if (q0.size() == 0) chk("sb0_unexpected_emit", q0.size(), 1);
        else begin
          e = q0.pop_front();
          chk("sb0_emit", {out_ctrl0, out_data0}, e);
        end
      end
      if (in_valid && in_ready0) q0.push_back({in_ctrl, in_data});
      if (!out_valid0) chk("gate0", {out_ctrl0, out_data0}, 0);

      if (out_valid1 && out_ready) begin
        if (q1.size() == 0) chk("sb1_unexpected_emit", q1.size(), 1);
        else begin
          e = q1.pop_front();
          chk("sb1_emit", {out_ctrl1, out_data1}, e);
        end
      end
      if (in_valid && in_ready1) q1.push_back({in_ctrl, in_data});
      if (!out_valid1) chk("gate1", {out_ctrl1, out_data1}, 0);
    end
  end

  initial begin
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] b0, b1;
`endif
    reset = 1'b1;
    drive(0, '0, '0, 0, 0);
    #12;
    chk("rst_ov0", out_valid0, 0);
    chk("rst_ov1", out_valid1, 0);
    chk("rst_ir0", in_ready0, 1);
    chk("rst_ir1", in_ready1, 1);
    chk("rst_od1", {out_ctrl1, out_data1}, 0);
    reset = 1'b0;
    step();

    // Back-to-back stream 1..4 with downstream always ready
    for (int k = 1; k <= 4; k++) begin
      drive(1, DATA_W'(k), 4'h3, 1, 0);
      step();
      chk("b2b_ov0", out_valid0, 1);
      chk("b2b_od0", out_data0, k);
      chk("b2b_ov1", out_valid1, 1);
      chk("b2b_od1", out_data1, k);
    end
    drive(0, '0, '0, 1, 0);
    step();
    chk("b2b_end_ov0", out_valid0, 0);
    chk("b2b_end_ov1", out_valid1, 0);

    // SKID=0 stall: 0xAA held for 3 cycles, then a single emit
    drive(1, 'hAA, 4'h1, 0, 0);
    step();
    drive(0, '0, '0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ir0", in_ready0, 0);
      chk("stall_od0", out_data0, 'hAA);
      chk("stall_ov0", out_valid0, 1);
    end
    drive(0, '0, '0, 1, 0);
    step();
    chk("stall_single_ov0", out_valid0, 0);
    chk("stall_single_ov1", out_valid1, 0);

    // SKID=1 fill to FULL: 0x11, 0x22 held, 0x33 refused
    drive(1, 'h11, 4'h4, 0, 0);
    step();
    chk("fill_ir1_one", in_ready1, 1);
    drive(1, 'h22, 4'h5, 0, 0);
    step();
    chk("fill_ir1_full", in_ready1, 0);
    drive(1, 'h33, 4'h6, 0, 0);
    step();
    chk("fill_ir1_hold", in_ready1, 0);
    chk("fill_od1", out_data1, 'h11);
    step();
    chk("fill_od1_stable", out_data1, 'h11);
    chk("fill_oc1_stable", out_ctrl1, 4'h4);
    drive(0, '0, '0, 1, 0);
    step();
    chk("drain_ov1", out_valid1, 1);
    chk("drain_od1", out_data1, 'h22);
    chk("drain_ir1", in_ready1, 1);
    step();
    chk("drain_end_ov1", out_valid1, 0);
    chk("drain_end_ov0", out_valid0, 0);

    // Flush with one entry held and 4'hF offered in the flush cycle
    drive(1, 'h55, 4'h2, 0, 0);
    step();
    drive(1, 'h77, 4'hF, 0, 1);
    step();
    chk("flush_ov0", out_valid0, 0);
    chk("flush_ov1", out_valid1, 0);
    chk("flush_pl0", {out_ctrl0, out_data0}, 0);
    chk("flush_pl1", {out_ctrl1, out_data1}, 0);
    chk("flush_ir0", in_ready0, 1);
    chk("flush_ir1", in_ready1, 1);
    drive(0, '0, '0, 1, 0);
    for (int k = 0; k < 3; k++) step();
    chk("flush_quiet_ov0", out_valid0, 0);
    chk("flush_quiet_ov1", out_valid1, 0);

    // Asynchronous reset while SKID=1 is FULL
    drive(1, 'h61, 4'h7, 0, 0);
    step();
    drive(1, 'h62, 4'h8, 0, 0);
    step();
    drive(0, '0, '0, 0, 0);
    chk("arst_pre_ir1", in_ready1, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_ov0", out_valid0, 0);
    chk("arst_ov1", out_valid1, 0);
    chk("arst_pl1", {out_ctrl1, out_data1}, 0);
    chk("arst_ir1", in_ready1, 1);
    @(negedge clk);
    #1 reset = 1'b0;
    step();
    chk("arst_post_ir1", in_ready1, 1);
    chk("arst_post_ov1", out_valid1, 0);
    drive(1, 'h63, 4'h9, 1, 0);
    step();
    chk("arst_lat_od1", out_data1, 'h63);
    chk("arst_lat_od0", out_data0, 'h63);
    drive(0, '0, '0, 1, 0);
    step();

`ifdef PIPE_STAGE_PERF_EN
    // Perf counters: bubbles, then 5 stall cycles, then a flush
    reset = 1'b1;
    #2 reset = 1'b0;
    drive(0, '0, '0, 0, 0);
    for (int k = 0; k < 3; k++) step();
    drive(1, 'h99, 4'h1, 0, 0);
    step();
    drive(0, '0, '0, 0, 0);
    for (int k = 0; k < 5; k++) step();
    chk("perf_stall0", stall_cnt0, 5);
    chk("perf_stall1", stall_cnt1, 5);
    chk("perf_bub0_min", bubble_cnt0 >= 32'd3, 1);
    chk("perf_bub1_min", bubble_cnt1 >= 32'd3, 1);
    b0 = bubble_cnt0;
    b1 = bubble_cnt1;
    drive(0, '0, '0, 1, 1);
    step();
    chk("perf_flush_stall0", stall_cnt0, 5);
    chk("perf_flush_stall1", stall_cnt1, 5);
    chk("perf_flush_bub0", bubble_cnt0, b0);
    chk("perf_flush_bub1", bubble_cnt1, b1);
    drive(0, '0, '0, 1, 0);
    step();
`endif

    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
